axil_mem_arbiter: RTL
=====================

AXIL_MEM_ARBITER -- requirements
Module: axil_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width on all ports.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, write-strobe width.
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous, active-low.
REQ-006 s0_axil_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  master 0 write address.
REQ-007 s0_axil_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  master 0 write data.
REQ-008 s0_axil_bresp/bvalid/bready  out/out/in  2/1/1  master 0 write response.
REQ-009 s0_axil_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  master 0 read address.
REQ-010 s0_axil_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  master 0 read data.
REQ-011 s1_axil_* (aw, w, b, ar, r)  same directions and widths as REQ-006..010  master 1.
REQ-012 m_axil_* (aw, w, b, ar, r)  directions mirrored, same widths  port to shared memory slave.
REQ-013 grant  out  2  one-hot owner of slave port (bit0 = master 0, bit1 = master 1); 00 when idle.

Function
REQ-014 Shall use states IDLE, WRITE, WRESP, RADDR, RDATA, plus register last_grant (1 bit).
REQ-015 Master request: awvalid || arvalid of that master, sampled in IDLE only.
REQ-016 IDLE, one requester: grant it; both requesting: grant master != last_grant (round-robin).
REQ-017 Granted master with awvalid -> WRITE; else -> RADDR; simultaneous awvalid and arvalid -> write first.
REQ-018 Grant taken on the IDLE edge; request first visible in cycle N appears on m_axil_* in cycle N+1.
REQ-019 In WRITE, granted master's AW and W channels shall be routed combinationally to m_axil_*.
REQ-020 In WRITE, aw_done/w_done flags set on the respective m_axil handshake; done channel's m valid and s ready forced 0.
REQ-021 AW and W handshakes may complete in either order or the same cycle; both done -> WRESP, flags cleared.
REQ-022 In WRESP, m_axil_b routed to granted master; on bvalid && bready -> IDLE, last_grant <= granted index.
REQ-023 In RADDR, AR routed; on m_axil_arvalid && arready -> RDATA.
REQ-024 In RDATA, m_axil_r routed to granted master; on rvalid && rready -> IDLE, last_grant updated.
REQ-025 Non-granted master: all ready and valid outputs 0, data/resp outputs 0.
REQ-026 Slave port outside its active channel: all valid/ready outputs 0.
REQ-027 m_axil_bready/rready shall be 0 outside WRESP/RDATA; responses outside those states are not accepted.
REQ-028 Exactly one transaction outstanding at a time; IDLE lasts at least one cycle between transactions.
REQ-029 Master dropping valid before its handshake is an AXI violation; behaviour undefined, no check required.
REQ-030 Payload (addr, prot, data, strb, resp) passed unmodified; no width conversion.

Reset
REQ-031 aresetn low shall force IDLE, aw_done = w_done = 0, last_grant = 1, grant = 00 immediately, without clock.
REQ-032 During reset all valid and ready outputs shall be 0.
REQ-033 Reset mid-transaction abandons it; no response delivered to either master afterwards.
REQ-034 After release, first arbitration grants master 0 when both request.

Verification
REQ-035 Reset, then s0 write addr 0x10 data 0xDEADBEEF strb 0xF -> m AW/W in cycle after request; s0 bvalid once; grant = 01.
REQ-036 s0 and s1 both assert arvalid same cycle -> s0 served first, then s1; with both held requesting, grants alternate 01, 10, 01.
REQ-037 s1 asserts awvalid and arvalid together -> write completes (B to s1), then read issued in a later transaction.
REQ-038 Slave accepts W two cycles before AW -> single write, WRESP entered after AW handshake, W not re-presented.
REQ-039 s0 read with m rvalid held, s0 rready low 5 cycles -> s1 awready stays 0, grant stays 01 until s0 rready.
REQ-040 aresetn low during WRESP -> grant = 00, all valids 0 same cycle; no bvalid on s0 after release.

Source files
------------

// File: rtl/axil_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axil_mem_arbiter
//
// Purpose:
//   Shares one AXI4-Lite memory slave between two AXI4-Lite masters.
//   Only one transaction (a single write or a single read) is in flight at
//   any time. When both masters request in the same cycle, they take turns
//   (round-robin). A write takes priority over a read from the same master.
//
// Ports:
//   aclk, aresetn   clock (rising edge) and asynchronous active-low reset
//   s0_axil_*       AXI4-Lite slave port facing master 0 (aw, w, b, ar, r)
//   s1_axil_*       AXI4-Lite slave port facing master 1 (aw, w, b, ar, r)
//   m_axil_*        AXI4-Lite master port facing the shared memory slave
//   grant           one-hot current owner (bit0 = master 0, bit1 = master 1),
//                   00 while idle
// ---------------------------------------------------------------------------
module axil_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // master 0
  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  // master 1
  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  // shared slave
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [1:0]            grant
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

  state_t r_state, w_nextState;
  logic   r_grantIdx, w_nextGrantIdx;
  logic   r_lastGrant, w_nextLastGrant;
  logic   r_awDone, w_nextAwDone;
  logic   r_wDone, w_nextWDone;

  logic                  w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic                  w_awHs, w_wHs;
  logic                  w_awReady, w_wReady, w_bValid, w_arReady, w_rValid;
  logic                  w_req0, w_req1, w_pick;

  // Channel signals of whichever master currently owns the slave port.
  // The payload goes straight through; only valid/ready are qualified.
  assign w_awvalid      = r_grantIdx ? s1_axil_awvalid : s0_axil_awvalid;
  assign w_wvalid       = r_grantIdx ? s1_axil_wvalid  : s0_axil_wvalid;
  assign w_bready       = r_grantIdx ? s1_axil_bready  : s0_axil_bready;
  assign w_arvalid      = r_grantIdx ? s1_axil_arvalid : s0_axil_arvalid;
  assign w_rready       = r_grantIdx ? s1_axil_rready  : s0_axil_rready;
  assign m_axil_awaddr  = r_grantIdx ? s1_axil_awaddr  : s0_axil_awaddr;
  assign m_axil_awprot  = r_grantIdx ? s1_axil_awprot  : s0_axil_awprot;
  assign m_axil_wdata   = r_grantIdx ? s1_axil_wdata   : s0_axil_wdata;
  assign m_axil_wstrb   = r_grantIdx ? s1_axil_wstrb   : s0_axil_wstrb;
  assign m_axil_araddr  = r_grantIdx ? s1_axil_araddr  : s0_axil_araddr;
  assign m_axil_arprot  = r_grantIdx ? s1_axil_arprot  : s0_axil_arprot;

  // A channel that already handshook is blanked so it is never presented twice.
  assign w_awHs = (r_state == WRITE) && !r_awDone && w_awvalid && m_axil_awready;
  assign w_wHs  = (r_state == WRITE) && !r_wDone  && w_wvalid  && m_axil_wready;

  // Round-robin: on a tie, the master that did not win last time goes next.
  assign w_req0 = s0_axil_awvalid || s0_axil_arvalid;
  assign w_req1 = s1_axil_awvalid || s1_axil_arvalid;
  assign w_pick = (w_req0 && w_req1) ? ~r_lastGrant : w_req1;

  assign grant = (r_state == IDLE) ? 2'b00 : (r_grantIdx ? 2'b10 : 2'b01);

  // State register plus the bookkeeping bits; reset drops straight to IDLE,
  // abandoning anything in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_grantIdx  <= 1'b0;
      r_lastGrant <= 1'b1;
      r_awDone    <= 1'b0;
      r_wDone     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_grantIdx  <= w_nextGrantIdx;
      r_lastGrant <= w_nextLastGrant;
      r_awDone    <= w_nextAwDone;
      r_wDone     <= w_nextWDone;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE; the write side
  // waits until both AW and W have handshook, in whichever order.
  always_comb begin
    w_nextState     = r_state;
    w_nextGrantIdx  = r_grantIdx;
    w_nextLastGrant = r_lastGrant;
    w_nextAwDone    = r_awDone;
    w_nextWDone     = r_wDone;
    case (r_state)
      IDLE: begin
        if (w_req0 || w_req1) begin
          w_nextGrantIdx = w_pick;
          w_nextState    = (w_pick ? s1_axil_awvalid : s0_axil_awvalid) ? WRITE : RADDR;
        end
      end
      WRITE: begin
        if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) begin
          w_nextState  = WRESP;
          w_nextAwDone = 1'b0;
          w_nextWDone  = 1'b0;
        end else begin
          w_nextAwDone = r_awDone || w_awHs;
          w_nextWDone  = r_wDone  || w_wHs;
        end
      end
      WRESP: begin
        if (m_axil_bvalid && w_bready) begin
          w_nextState     = IDLE;
          w_nextLastGrant = r_grantIdx;
        end
      end
      RADDR: begin
        if (w_arvalid && m_axil_arready) begin
          w_nextState = RDATA;
        end
      end
      RDATA: begin
        if (m_axil_rvalid && w_rready) begin
          w_nextState     = IDLE;
          w_nextLastGrant = r_grantIdx;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Valid/ready steering: only the channel belonging to the current state is
  // opened; everything else on the slave port stays quiet.
  always_comb begin
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    w_awReady      = 1'b0;
    w_wReady       = 1'b0;
    w_bValid       = 1'b0;
    w_arReady      = 1'b0;
    w_rValid       = 1'b0;
    case (r_state)
      WRITE: begin
        m_axil_awvalid = w_awvalid && !r_awDone;
        m_axil_wvalid  = w_wvalid  && !r_wDone;
        w_awReady      = m_axil_awready && !r_awDone;
        w_wReady       = m_axil_wready  && !r_wDone;
      end
      WRESP: begin
        m_axil_bready = w_bready;
        w_bValid      = m_axil_bvalid;
      end
      RADDR: begin
        m_axil_arvalid = w_arvalid;
        w_arReady      = m_axil_arready;
      end
      RDATA: begin
        m_axil_rready = w_rready;
        w_rValid      = m_axil_rvalid;
      end
      default: ;
    endcase
  end

  // Fan the steered handshakes and response payload back to the owning
  // master only; the other master sees zeros everywhere.
  always_comb begin
    s0_axil_awready = w_awReady && !r_grantIdx;
    s0_axil_wready  = w_wReady  && !r_grantIdx;
    s0_axil_bvalid  = w_bValid  && !r_grantIdx;
    s0_axil_arready = w_arReady && !r_grantIdx;
    s0_axil_rvalid  = w_rValid  && !r_grantIdx;
    s1_axil_awready = w_awReady && r_grantIdx;
    s1_axil_wready  = w_wReady  && r_grantIdx;
    s1_axil_bvalid  = w_bValid  && r_grantIdx;
    s1_axil_arready = w_arReady && r_grantIdx;
    s1_axil_rvalid  = w_rValid  && r_grantIdx;
    s0_axil_bresp   = (r_state == WRESP && !r_grantIdx) ? m_axil_bresp : 2'b00;
    s1_axil_bresp   = (r_state == WRESP &&  r_grantIdx) ? m_axil_bresp : 2'b00;
    s0_axil_rresp   = (r_state == RDATA && !r_grantIdx) ? m_axil_rresp : 2'b00;
    s1_axil_rresp   = (r_state == RDATA &&  r_grantIdx) ? m_axil_rresp : 2'b00;
    s0_axil_rdata   = (r_state == RDATA && !r_grantIdx) ? m_axil_rdata : '0;
    s1_axil_rdata   = (r_state == RDATA &&  r_grantIdx) ? m_axil_rdata : '0;
  end

endmodule
